// File: rtl/example_pkg.sv
// Shared constants and types for the example event/cycle counter.
package example_pkg;

    localparam int default_width_c = 8;

    typedef logic [default_width_c-1:0] count_t;

endpackage : example_pkg

// File: rtl/example_reg.sv
// Width-parameterized register with asynchronous active-low clear and load enable.
module example_reg
    import example_pkg::*;
#(
    parameter int width_p = default_width_c
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] d_i,
    output logic [width_p-1:0] q_o
);

    logic [width_p-1:0] q_reg;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            q_reg <= '0;
        end else if (en_i) begin
            q_reg <= d_i;
        end
    end

    assign q_o = q_reg;

endmodule : example_reg

// File: rtl/example.sv
// Free-running up-counter with count enable; wraps modulo 2^width_p, async active-low clear.
module example
    import example_pkg::*;
#(
    parameter int width_p = default_width_c
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o
);

    if (width_p < 1 || width_p > 32) begin : g_bad_width
        $error("example: width_p must be in 1..32");
    end

    logic [width_p-1:0] count_next;

    // Carry out of the top bit is dropped, giving the modulo wrap for free.
    assign count_next = count_o + 1'b1;

    example_reg #(
        .width_p (width_p)
    ) u_count_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (en_i),
        .d_i     (count_next),
        .q_o     (count_o)
    );

`ifndef SYNTHESIS
    a_reset_clears : assert property (@(posedge clk_i)
        !reset_i |-> (count_o == '0))
        else $error("example: count not cleared while in reset");

    a_count_inc : assert property (@(posedge clk_i) disable iff (!reset_i)
        en_i |=> (count_o == $past(count_o) + 1'b1))
        else $error("example: enabled count did not advance by one");

    a_count_hold : assert property (@(posedge clk_i) disable iff (!reset_i)
        !en_i |=> (count_o == $past(count_o)))
        else $error("example: disabled count did not hold");
`endif

endmodule : example

// File: tb/tb_example.sv
// Directed self-checking bench for the example counter at the default 8-bit width.
`timescale 1ns/1ps
module tb_example;
    import example_pkg::*;

    logic   clk_i   = 1'b0;
    logic   reset_i = 1'b0;
    logic   en_i    = 1'b0;
    count_t count_o;

    int checks = 0;
    int errors = 0;

    example #(
        .width_p (default_width_c)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (en_i),
        .count_o (count_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        assert (!$isunknown(en_i)) else $error("tb: en_i unknown at posedge");
    end

    initial begin
        #10000;
        $display("FAIL watchdog: simulation still running at %0t, required finish before 10 us", $time);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: count %0d at %0t", tag, got, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // 1: reset held low
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("s1_reset_hold", 32'(count_o), 32'd0);
        end

        // 2: release, idle one cycle, then count 1..20
        reset_i = 1'b1;
        step();
        check_val("s2_idle_after_release", 32'(count_o), 32'd0);
        en_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            check_val("s2_count", 32'(count_o), 32'(i));
        end

        // 3: hold at 20, then resume to 30
        en_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("s3_hold", 32'(count_o), 32'd20);
        end
        en_i = 1'b1;
        for (int i = 21; i <= 30; i++) begin
            step();
            check_val("s3_resume", 32'(count_o), 32'(i));
        end

        // 4: reset mid-count with enable still high
        reset_i = 1'b0;
        #1;
        check_val("s4_async_clear", 32'(count_o), 32'd0);
        step();
        check_val("s4_reset_beats_en", 32'(count_o), 32'd0);
        reset_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check_val("s4_recount", 32'(count_o), 32'(i));
        end

        // 5: wrap through 255 -> 0 -> 1
        reset_i = 1'b0;
        step();
        check_val("s5_reset", 32'(count_o), 32'd0);
        reset_i = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            step();
            check_val((i >= 255) ? "s5_wrap" : "s5_count", 32'(count_o), 32'(i % 256));
        end

        // 6: reset asserted between edges clears within the half-period
        step();
        check_val("s6_pre", 32'(count_o), 32'd2);
        #2;
        reset_i = 1'b0;
        #1;
        check_val("s6_async_midcycle", 32'(count_o), 32'd0);
        step();
        check_val("s6_reset_held", 32'(count_o), 32'd0);
        reset_i = 1'b1;
        step();
        check_val("s6_restart", 32'(count_o), 32'd1);
        en_i = 1'b0;
        step();
        check_val("s6_final_hold", 32'(count_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_example
